sim_concurrency_arbiter: RTL and testbench
==========================================

SIM_CONCURRENCY_ARBITER -- requirements
Module: sim_concurrency_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, payload width per requester.
REQ-003 SHALL have parameter MAX_CONCURRENCY, default 8, global in-flight cap; 0 = unlimited.
REQ-004 SHALL have parameter PER_REQ_MAX, default 4, per-requester in-flight cap; 0 = unlimited.
REQ-005 SHALL have ports clk in 1, the single clock; rst_n in 1, reset, asynchronous and active-low.
REQ-006 SHALL have ports req_valid in NUM_REQ; req_ready out NUM_REQ; req_data in NUM_REQ*DATA_WIDTH, requester i at slice i.
REQ-007 SHALL have ports grant_valid out 1; grant_data out DATA_WIDTH; grant_id out $clog2(NUM_REQ); grant_ready in 1.
REQ-008 SHALL have ports ack_valid in 1 and ack_id in $clog2(NUM_REQ); these return one credit per cycle.
REQ-009 SHALL have ports drain_req in 1; drained out 1; err_underflow out 1 (sticky); stall_count out 32.

Function
REQ-010 Requester i SHALL be eligible when all hold: req_valid[i]; inflight[i] < PER_REQ_MAX or PER_REQ_MAX==0; total < MAX_CONCURRENCY or MAX_CONCURRENCY==0; state==RUN.
REQ-011 Winner SHALL be the first eligible index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
REQ-012 grant_valid SHALL equal any-eligible, combinationally; grant_data and grant_id SHALL equal the winner's data and index, with zero added latency.
REQ-013 req_ready[i] SHALL be high only when i is the winner and grant_ready is high; it SHALL be 0 for all others.
REQ-014 On a handshake (grant_valid && grant_ready), rr_ptr SHALL become (winner+1) mod NUM_REQ on the next edge; otherwise rr_ptr SHALL hold.
REQ-015 A handshake SHALL increment inflight[winner] and total; ack_valid SHALL decrement inflight[ack_id] and total.
REQ-016 When a handshake and an ack occur in the same cycle on the same id, that counter SHALL be unchanged; total SHALL also be unchanged.
REQ-017 An ack_valid while inflight[ack_id]==0 SHALL leave all counters unchanged and set err_underflow until reset.
REQ-018 An ack_valid with ack_id >= NUM_REQ SHALL be treated as underflow.
REQ-019 Counter widths SHALL hold the cap exactly, with no wrap; unlimited caps SHALL use a 16-bit saturating counter.
REQ-020 FSM states SHALL be RUN, DRAIN, DRAINED; RUN->DRAIN when drain_req==1; DRAIN->DRAINED when total==0 (same evaluation cycle, checked after acks); DRAINED->RUN when drain_req==0; DRAIN->RUN when drain_req drops before total reaches 0.
REQ-021 No grants SHALL issue in DRAIN or DRAINED; acks SHALL still be processed.
REQ-022 drained SHALL be 1 only in state DRAINED.
REQ-023 A requester whose grant was offered but not taken (grant_ready low) SHALL keep no priority beyond rr_ptr, which is unchanged.

Reset
REQ-024 While rst_n==0, asynchronously: state=RUN, rr_ptr=0, all inflight and total=0, err_underflow=0, stall_count=0, drained=0.
REQ-025 While rst_n==0, grant_valid and all req_ready SHALL be forced to 0.
REQ-026 Reset asserted mid-transaction SHALL discard all outstanding credits; acks arriving after reset release SHALL be underflow.

Configuration
REQ-027 Macro SIM_CONCURRENCY_ARBITER_STATS_EN defined: stall_count SHALL increment (saturating at 2^32-1) each cycle where state==RUN, some req_valid is 1 and grant_valid is 0.
REQ-028 Macro undefined: stall_count SHALL be tied to 0 and no counter logic SHALL be synthesized.

Verification
REQ-029 All 4 requesters valid, grant_ready=1, no acks, caps 8/4: grant order 0,1,2,3,0,1,2,3, then grant_valid=0; total==8.
REQ-030 Only req 2 valid, PER_REQ_MAX=4: 4 grants to id 2, then stall; one ack id 2 -> exactly one more grant next cycle.
REQ-031 inflight[1]==1; same-cycle grant id 1 and ack id 1 -> inflight[1] stays 1, total unchanged.
REQ-032 Ack id 3 while inflight[3]==0 -> err_underflow=1 persisting, counters unchanged; rst_n pulse clears it.
REQ-033 total==3, drain_req=1 -> no grants; after 3 acks, drained=1 next cycle; drain_req=0 -> grants resume from rr_ptr.
REQ-034 With STATS_EN, 5 cycles of req_valid=1 at full cap -> stall_count==5; without STATS_EN, stall_count==0.

Source files
------------

// File: rtl/sim_concurrency_arbiter_if.sv
// rtl/sim_concurrency_arbiter_if.sv - request/grant/ack bundle between requesters and the concurrency arbiter
interface sim_concurrency_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          grant_valid;
    logic [DATA_WIDTH-1:0]         grant_data;
    logic [ID_W-1:0]               grant_id;
    logic                          grant_ready;
    logic                          ack_valid;
    logic [ID_W-1:0]               ack_id;

    modport master (
        output req_valid, req_data, grant_ready, ack_valid, ack_id,
        input  req_ready, grant_valid, grant_data, grant_id
    );

    modport slave (
        input  req_valid, req_data, grant_ready, ack_valid, ack_id,
        output req_ready, grant_valid, grant_data, grant_id
    );
endinterface

// File: rtl/sim_concurrency_arbiter.sv
// rtl/sim_concurrency_arbiter.sv - round-robin arbiter with global/per-requester in-flight credit caps and drain FSM
// Optional stall statistics counter: define SIM_CONCURRENCY_ARBITER_STATS_EN.
module sim_concurrency_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_CONCURRENCY = 8,
    parameter int PER_REQ_MAX     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sim_concurrency_arbiter_if.slave bus,
    input  logic                     drain_req,
    output logic                     drained,
    output logic                     err_underflow,
    output logic [31:0]              stall_count
);
    localparam int ID_W = $clog2(NUM_REQ);
    // Capped counters are sized to hold the cap exactly; unlimited ones get 16 saturating bits.
    localparam int PW = (PER_REQ_MAX == 0) ? 16 : $clog2(PER_REQ_MAX + 1);
    localparam int TW = (MAX_CONCURRENCY == 0) ? 16 : $clog2(MAX_CONCURRENCY + 1);
    localparam logic [PW-1:0] P_CAP = PW'(PER_REQ_MAX);
    localparam logic [TW-1:0] T_CAP = TW'(MAX_CONCURRENCY);

    typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [PW-1:0]   inflight [NUM_REQ];
    logic [TW-1:0]   total;
    logic [TW-1:0]   total_next;

    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    inc_vec;
    logic [NUM_REQ-1:0]    dec_vec;
    logic                  total_ok;
    logic                  found;
    logic [ID_W-1:0]       winner;
    logic [ID_W-1:0]       cand;
    logic                  hs;
    logic                  ack_in_range;
    logic                  ack_hit;
    logic                  ack_bad;

    always_comb begin
        total_ok = (MAX_CONCURRENCY == 0) || (total < T_CAP);
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            eligible[i] = rst_n && (state == RUN) && total_ok && bus.req_valid[i] &&
                          ((PER_REQ_MAX == 0) || (inflight[i] < P_CAP));
        end
    end

    // Rotating scan: the first eligible index at or after rr_ptr wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign hs              = found && bus.grant_ready;
    assign bus.grant_valid = found;
    assign bus.grant_id    = winner;
    assign bus.grant_data  = data_arr[winner];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = hs && (winner == ID_W'(i));
        end
    end

    // An out-of-range id or an ack against an empty counter is an underflow with no effect.
    assign ack_in_range = (int'(bus.ack_id) < NUM_REQ);
    assign ack_hit      = bus.ack_valid && ack_in_range && (inflight[bus.ack_id] != '0);
    assign ack_bad      = bus.ack_valid && !ack_hit;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            inc_vec[i] = hs && (winner == ID_W'(i)) && (inflight[i] != '1);
            dec_vec[i] = ack_hit && (bus.ack_id == ID_W'(i));
        end
        total_next = total;
        if (hs && !ack_hit) begin
            if (total != '1) total_next = total + 1'b1;
        end else if (!hs && ack_hit) begin
            if (total != '0) total_next = total - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            total         <= '0;
            err_underflow <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) inflight[i] <= '0;
        end else begin
            total <= total_next;
            if (hs) rr_ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            if (ack_bad) err_underflow <= 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (inc_vec[i] && !dec_vec[i])      inflight[i] <= inflight[i] + 1'b1;
                else if (!inc_vec[i] && dec_vec[i]) inflight[i] <= inflight[i] - 1'b1;
            end
        end
    end

    // Drain completion looks at the post-ack total so DRAINED is reached on the last ack's edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            drained <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (drain_req) state <= DRAIN;
                    drained <= 1'b0;
                end
                DRAIN: begin
                    if (!drain_req) begin
                        state   <= RUN;
                        drained <= 1'b0;
                    end else if (total_next == '0) begin
                        state   <= DRAINED;
                        drained <= 1'b1;
                    end
                end
                DRAINED: begin
                    if (!drain_req) begin
                        state   <= RUN;
                        drained <= 1'b0;
                    end
                end
                default: begin
                    state   <= RUN;
                    drained <= 1'b0;
                end
            endcase
        end
    end

`ifdef SIM_CONCURRENCY_ARBITER_STATS_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if ((state == RUN) && (|bus.req_valid) && !found && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 32'd0;
`endif
endmodule

// File: tb/tb_sim_concurrency_arbiter.sv
// tb/tb_sim_concurrency_arbiter.sv - self-checking bench for sim_concurrency_arbiter (4 requesters, caps 8/4)
`timescale 1ns/1ps
module tb_sim_concurrency_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        drain_req = 1'b0;
    logic        drained;
    logic        err_underflow;
    logic [31:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    sim_concurrency_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus ();

    sim_concurrency_arbiter #(
        .NUM_REQ(4), .DATA_WIDTH(32), .MAX_CONCURRENCY(8), .PER_REQ_MAX(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .drain_req(drain_req),
        .drained(drained),
        .err_underflow(err_underflow),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

`ifdef SIM_CONCURRENCY_ARBITER_STATS_EN
    localparam logic [31:0] EXP_STALL = 32'd5;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0] rv;
        logic       gr;
        logic       av;
        logic [1:0] aid;
        logic       gv;
        logic [1:0] gid;
        logic [3:0] rdy;
    } vec_t;
    vec_t vt[9];

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h111;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int id);
        exp_t e;
        e.id   = 2'(id);
        e.data = pat(id);
        sb.push_back(e);
    endtask

    // Entered at a negedge; samples each cycle at +1ns and pops on every observed handshake.
    task automatic drain_sb(input string name, input int budget);
        exp_t e;
        for (int c = 0; c < budget && sb.size() > 0; c++) begin
            #1;
            if (bus.grant_valid && bus.grant_ready) begin
                e = sb.pop_front();
                check({name, "_id"}, 32'(bus.grant_id), 32'(e.id));
                check({name, "_data"}, bus.grant_data, e.data);
                check({name, "_ready"}, 32'(bus.req_ready), 32'(4'b0001 << e.id));
            end
            @(negedge clk);
        end
        check({name, "_all_grants_seen"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        drain_req     = 1'b0;
        bus.req_valid = '0;
        bus.ack_valid = 1'b0;
        bus.ack_id    = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000};
        vt[1] = '{4'b0100, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 4'b0000};
        vt[2] = '{4'b1010, 1'b1, 1'b0, 2'd0, 1'b1, 2'd1, 4'b0010};
        vt[3] = '{4'b1010, 1'b1, 1'b0, 2'd0, 1'b1, 2'd3, 4'b1000};
        vt[4] = '{4'b0011, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 4'b0000};
        vt[5] = '{4'b0011, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 4'b0001};
        vt[6] = '{4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 2'd1, 4'b0010};
        vt[7] = '{4'b0000, 1'b1, 1'b1, 2'd3, 1'b0, 2'd0, 4'b0000};
        vt[8] = '{4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 4'b0000};

        bus.req_data    = {pat(3), pat(2), pat(1), pat(0)};
        bus.req_valid   = '0;
        bus.grant_ready = 1'b0;
        bus.ack_valid   = 1'b0;
        bus.ack_id      = '0;

        // Outputs forced quiet while reset is held, even with requests pending.
        @(negedge clk);
        bus.req_valid   = 4'hF;
        bus.grant_ready = 1'b1;
        #1;
        check("rst_grant_valid", 32'(bus.grant_valid), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_drained", 32'(drained), 32'd0);
        check("rst_err_underflow", 32'(err_underflow), 32'd0);
        check("rst_stall_count", stall_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // All four requesting: two round-robin laps fill the global cap of 8.
        for (int lap = 0; lap < 2; lap++)
            for (int i = 0; i < 4; i++) push(i);
        drain_sb("rr_order", 20);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("global_cap_stall", 32'(bus.grant_valid), 32'd0);
            @(negedge clk);
        end
        #1;
        check("global_total", 32'(dut.total), 32'd8);
        check("stall_count", stall_count, EXP_STALL);
        @(negedge clk);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            bus.req_valid   = vt[i].rv;
            bus.grant_ready = vt[i].gr;
            bus.ack_valid   = vt[i].av;
            bus.ack_id      = vt[i].aid;
            #1;
            check($sformatf("vec%0d_grant_valid", i), 32'(bus.grant_valid), 32'(vt[i].gv));
            check($sformatf("vec%0d_req_ready", i), 32'(bus.req_ready), 32'(vt[i].rdy));
            if (vt[i].gv) begin
                check($sformatf("vec%0d_grant_id", i), 32'(bus.grant_id), 32'(vt[i].gid));
                check($sformatf("vec%0d_grant_data", i), bus.grant_data, pat(int'(vt[i].gid)));
            end
            @(negedge clk);
        end
        bus.ack_valid = 1'b0;
        #1;
        check("same_cycle_inflight1", 32'(dut.inflight[1]), 32'd1);
        check("table_total", 32'(dut.total), 32'd1);
        check("table_no_underflow", 32'(err_underflow), 32'd0);

        // Ack to an empty requester: sticky error, credits untouched.
        @(negedge clk);
        bus.ack_valid = 1'b1;
        bus.ack_id    = 2'd3;
        @(negedge clk);
        bus.ack_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("underflow_sticky", 32'(err_underflow), 32'd1);
        check("underflow_total", 32'(dut.total), 32'd1);
        check("underflow_inflight1", 32'(dut.inflight[1]), 32'd1);
        @(negedge clk);
        do_reset();
        #1;
        check("underflow_cleared", 32'(err_underflow), 32'd0);
        @(negedge clk);
        bus.ack_valid = 1'b1;
        bus.ack_id    = 2'd1;
        @(negedge clk);
        bus.ack_valid = 1'b0;
        #1;
        check("ack_after_reset_underflow", 32'(err_underflow), 32'd1);
        check("ack_after_reset_total", 32'(dut.total), 32'd0);
        @(negedge clk);

        // Single requester hits its per-requester cap; one ack frees exactly one grant.
        do_reset();
        bus.req_valid   = 4'b0100;
        bus.grant_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(2);
        drain_sb("per_cap", 10);
        #1;
        check("per_cap_stall", 32'(bus.grant_valid), 32'd0);
        bus.ack_valid = 1'b1;
        bus.ack_id    = 2'd2;
        #1;
        check("per_cap_ack_cycle", 32'(bus.grant_valid), 32'd0);
        @(negedge clk);
        bus.ack_valid = 1'b0;
        push(2);
        drain_sb("per_cap_regrant", 1);
        #1;
        check("per_cap_restall", 32'(bus.grant_valid), 32'd0);
        @(negedge clk);

        // Drain with three credits outstanding, then resume from rr_ptr (3).
        do_reset();
        bus.req_valid = 4'b0111;
        for (int i = 0; i < 3; i++) push(i);
        drain_sb("pre_drain", 6);
        bus.req_valid = 4'b0000;
        drain_req     = 1'b1;
        @(negedge clk);
        bus.req_valid = 4'hF;
        #1;
        check("drain_grant_valid", 32'(bus.grant_valid), 32'd0);
        check("drain_not_drained", 32'(drained), 32'd0);
        for (int a = 0; a < 3; a++) begin
            bus.ack_valid = 1'b1;
            bus.ack_id    = 2'(a);
            #1;
            check($sformatf("drain_ack%0d_no_grant", a), 32'(bus.grant_valid), 32'd0);
            check($sformatf("drain_ack%0d_drained", a), 32'(drained), 32'd0);
            @(negedge clk);
        end
        bus.ack_valid = 1'b0;
        #1;
        check("drained_set", 32'(drained), 32'd1);
        check("drained_no_grant", 32'(bus.grant_valid), 32'd0);
        drain_req = 1'b0;
        #1;
        check("drained_release_cycle", 32'(bus.grant_valid), 32'd0);
        @(negedge clk);
        push(3);
        drain_sb("resume", 1);
        check("resume_drained_clear", 32'(drained), 32'd0);
        check("final_no_underflow", 32'(err_underflow), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
